// File: rtl/rand_range_if.sv
// Request/result bundle for rand_range.
// The master side issues requests and consumes results; the slave side is the
// range reducer itself.
interface rand_range_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] limit;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_fallback;
  logic         out_err;
  logic [15:0]  rej_cnt;

  modport master (
    output start, limit, out_ready,
    input  busy, out_valid, out_data, out_fallback, out_err, rej_cnt
  );

  modport slave (
    input  start, limit, out_ready,
    output busy, out_valid, out_data, out_fallback, out_err, rej_cnt
  );
endinterface

// File: rtl/rand_range.sv
// rand_range: turns a free-running 32-bit random word into an unbiased integer
// in [0, limit) by masked rejection sampling. The low W bits of rnd are masked
// down to the smallest all-ones pattern covering limit-1; candidates >= limit
// are rejected. After MAX_TRY rejections the last candidate minus limit is
// returned instead, which is always in range because mask < 2*limit.
module rand_range #(
  parameter int W       = 16,
  parameter int MAX_TRY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rnd,
  rand_range_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ZERO     = {W{1'b0}};
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [7:0]   LAST_TRY = 8'(MAX_TRY - 1);
  localparam logic [15:0]  REJ_MAX  = 16'hFFFF;

  // Smallest 2^k-1 that is >= v: propagate the highest set bit downwards.
  function automatic logic [W-1:0] smear(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int s = 1; s < W; s = s * 2) begin
      r = r | (r >> s);
    end
    return r;
  endfunction

  // Saturating increment for the rejection statistic.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == REJ_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  state_t       state,    state_nx;
  logic [W-1:0] lim,      lim_nx;
  logic [W-1:0] mask,     mask_nx;
  logic [7:0]   try_cnt,  try_nx;
  logic [W-1:0] data,     data_nx;
  logic         valid,    valid_nx;
  logic         fallback, fallback_nx;
  logic         err,      err_nx;
  logic [15:0]  rej,      rej_nx;
  logic         busy,     busy_nx;
  logic [W-1:0] cand;

  // The bits above W are never consumed; fold them into a named sink.
  generate
    if (W < 32) begin : g_unused
      logic unused_rnd_hi;
      assign unused_rnd_hi = ^rnd[31:W];
    end
  endgenerate

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_nx    = state;
    lim_nx      = lim;
    mask_nx     = mask;
    try_nx      = try_cnt;
    data_nx     = data;
    valid_nx    = valid;
    fallback_nx = fallback;
    err_nx      = err;
    rej_nx      = rej;
    cand        = rnd[W-1:0] & mask;

    case (state)
      IDLE: begin
        if (bus.start) begin
          lim_nx   = bus.limit;
          try_nx   = 8'd0;
          state_nx = SETUP;
        end else begin
          state_nx = IDLE;
        end
      end

      SETUP: begin
        if (lim == ZERO) begin
          // An empty range cannot be sampled: report it as an error result.
          data_nx     = ZERO;
          err_nx      = 1'b1;
          fallback_nx = 1'b0;
          valid_nx    = 1'b1;
          state_nx    = DONE;
        end else begin
          mask_nx  = smear(lim - ONE);
          state_nx = DRAW;
        end
      end

      DRAW: begin
        if (cand < lim) begin
          data_nx     = cand;
          fallback_nx = 1'b0;
          err_nx      = 1'b0;
          valid_nx    = 1'b1;
          state_nx    = DONE;
        end else begin
          rej_nx = sat_inc(rej);
          try_nx = try_cnt + 8'd1;
          if (try_cnt == LAST_TRY) begin
            // Out of retries: fold the rejected candidate back into range.
            data_nx     = cand - lim;
            fallback_nx = 1'b1;
            err_nx      = 1'b0;
            valid_nx    = 1'b1;
            state_nx    = DONE;
          end else begin
            state_nx = DRAW;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end

      default: begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers; reset discards any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lim      <= ZERO;
      mask     <= ZERO;
      try_cnt  <= 8'd0;
      data     <= ZERO;
      valid    <= 1'b0;
      fallback <= 1'b0;
      err      <= 1'b0;
      rej      <= 16'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      lim      <= lim_nx;
      mask     <= mask_nx;
      try_cnt  <= try_nx;
      data     <= data_nx;
      valid    <= valid_nx;
      fallback <= fallback_nx;
      err      <= err_nx;
      rej      <= rej_nx;
      busy     <= busy_nx;
    end
  end

  assign bus.busy         = busy;
  assign bus.out_valid    = valid;
  assign bus.out_data     = data;
  assign bus.out_fallback = fallback;
  assign bus.out_err      = err;
  assign bus.rej_cnt      = rej;

endmodule

// File: tb/tb_rand_range.sv
// Self-checking bench for rand_range. A behavioural model computes each
// expected result from the rnd words fed to the design.
module tb_rand_range;

  localparam int MAX_TRY = 8;

  logic        clk;
  logic        rst;
  logic [31:0] rnd;
  logic [31:0] rnd_sat;

  int n_total;
  int n_pass;

  int rej_model;
  bit use_xs;
  logic [31:0] xs_x, xs_y, xs_z, xs_w;
  logic [31:0] rnd_q[$];

  rand_range_if #(.W(16)) bus ();
  rand_range_if #(.W(16)) sat_if ();

  rand_range #(.W(16), .MAX_TRY(MAX_TRY)) dut (
    .clk (clk),
    .rst (rst),
    .rnd (rnd),
    .bus (bus)
  );

  // Second instance with the largest retry budget drives rej_cnt into saturation.
  rand_range #(.W(16), .MAX_TRY(255)) dut_sat (
    .clk (clk),
    .rst (rst),
    .rnd (rnd_sat),
    .bus (sat_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xs_next(output logic [31:0] v);
    logic [31:0] t;
    t    = xs_x ^ (xs_x << 11);
    xs_x = xs_y;
    xs_y = xs_z;
    xs_z = xs_w;
    xs_w = xs_w ^ (xs_w >> 19) ^ (t ^ (t >> 8));
    v    = xs_w;
  endtask

  task automatic get_rnd(output logic [31:0] v);
    if (rnd_q.size() > 0) v = rnd_q.pop_front();
    else if (use_xs) xs_next(v);
    else v = $urandom;
  endtask

  // Issue one request, feed one rnd word per cycle, and predict the result.
  task automatic drive_req(input logic [15:0] lim, input bit accept,
                           output logic [15:0] got_d, output logic got_fb,
                           output logic got_er, output int got_lat,
                           output logic [15:0] exp_d, output logic exp_fb,
                           output logic exp_er, output int exp_lat);
    logic [31:0] v;
    logic [31:0] rec[$];
    int limv, m, c;
    bit done;
    bus.start = 1'b1;
    bus.limit = lim;
    get_rnd(v);
    rnd = v;
    tick();
    bus.start = 1'b0;
    got_lat = -1;
    for (int n = 1; n <= MAX_TRY + 3; n++) begin
      get_rnd(v);
      rnd = v;
      rec.push_back(v);
      tick();
      if (bus.out_valid) begin
        got_lat = n;
        break;
      end
    end
    while (rec.size() < MAX_TRY + 1) rec.push_back(32'h0);
    got_d  = bus.out_data;
    got_fb = bus.out_fallback;
    got_er = bus.out_err;
    // Model: rec[0] arrives during setup, draw k sees rec[k+1].
    exp_d = 16'h0; exp_fb = 1'b0; exp_er = 1'b0; exp_lat = 0;
    limv = int'(lim);
    if (limv == 0) begin
      exp_er  = 1'b1;
      exp_lat = 1;
    end else begin
      m = 0;
      while (m < limv - 1) m = m * 2 + 1;
      done = 1'b0;
      for (int k = 0; k < MAX_TRY && !done; k++) begin
        c = int'(rec[k+1][15:0]) & m;
        if (c < limv) begin
          exp_d   = 16'(c);
          exp_lat = 2 + k;
          done    = 1'b1;
        end else begin
          rej_model = (rej_model >= 65535) ? 65535 : rej_model + 1;
          if (k == MAX_TRY - 1) begin
            exp_d   = 16'(c - limv);
            exp_fb  = 1'b1;
            exp_lat = 2 + k;
          end
        end
      end
    end
    if (accept) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 16'h0) $display("FAIL reset_data: got %0h expected 0", bus.out_data); else n_pass++;
    n_total++; if ({bus.out_fallback, bus.out_err} !== 2'b00) $display("FAIL reset_flags: got %0b expected 00", {bus.out_fallback, bus.out_err}); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'h0) $display("FAIL reset_rej: got %0h expected 0", bus.rej_cnt); else n_pass++;
  endtask

  task automatic test_rejection();
    logic [15:0] gd, ed; logic gf, ef, ge, ee; int gl, el;
    rnd_q.push_back($urandom);
    rnd_q.push_back($urandom);
    rnd_q.push_back(32'h0007 | ($urandom << 16));
    rnd_q.push_back(32'h0006 | ($urandom << 16));
    rnd_q.push_back(32'h0003 | ($urandom << 16));
    drive_req(16'd6, 1'b0, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if (gl !== 4) $display("FAIL rej_latency: got %0d expected 4", gl); else n_pass++;
    n_total++; if (gd !== 16'd3) $display("FAIL rej_data: got %0h expected 3", gd); else n_pass++;
    n_total++; if (gf !== 1'b0) $display("FAIL rej_fallback: got %0b expected 0", gf); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'd2) $display("FAIL rej_cnt: got %0d expected 2", bus.rej_cnt); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd3}) $display("FAIL rej_hold: got %0b/%0h expected 1/3", bus.out_valid, bus.out_data); else n_pass++;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_total++; if ({bus.out_valid, bus.busy} !== 2'b00) $display("FAIL rej_drop: got %0b expected 00", {bus.out_valid, bus.busy}); else n_pass++;
    n_total++; if (bus.out_data !== 16'd3) $display("FAIL rej_keep_data: got %0h expected 3", bus.out_data); else n_pass++;
  endtask

  task automatic test_fallback();
    logic [15:0] gd, ed; logic gf, ef, ge, ee; int gl, el;
    rnd_q.push_back($urandom);
    rnd_q.push_back($urandom);
    for (int i = 0; i < MAX_TRY; i++) rnd_q.push_back(32'h0007 | ($urandom << 16));
    drive_req(16'd5, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if (gl !== 9) $display("FAIL fb_latency: got %0d expected 9", gl); else n_pass++;
    n_total++; if (gd !== 16'd2) $display("FAIL fb_data: got %0h expected 2", gd); else n_pass++;
    n_total++; if (gf !== 1'b1) $display("FAIL fb_flag: got %0b expected 1", gf); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'd10) $display("FAIL fb_rej: got %0d expected 10", bus.rej_cnt); else n_pass++;
  endtask

  task automatic test_edge_limits();
    logic [15:0] gd, ed; logic gf, ef, ge, ee; int gl, el;
    drive_req(16'd1, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if ({gl, gd, gf, ge} !== {32'd2, 16'd0, 2'b00}) $display("FAIL lim1: got lat %0d data %0h fb %0b err %0b expected 2/0/0/0", gl, gd, gf, ge); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'd10) $display("FAIL lim1_rej: got %0d expected 10", bus.rej_cnt); else n_pass++;
    drive_req(16'd0, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if ({gl, gd, gf, ge} !== {32'd1, 16'd0, 2'b01}) $display("FAIL lim0: got lat %0d data %0h fb %0b err %0b expected 1/0/0/1", gl, gd, gf, ge); else n_pass++;
    rnd_q.push_back($urandom);
    rnd_q.push_back($urandom);
    rnd_q.push_back(32'h1234FFFF);
    rnd_q.push_back(32'h0000ABCD);
    drive_req(16'hFFFF, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if ({gl, gd, gf, ge} !== {32'd3, 16'hABCD, 2'b00}) $display("FAIL limmax: got lat %0d data %0h fb %0b err %0b expected 3/abcd/0/0", gl, gd, gf, ge); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'd11) $display("FAIL limmax_rej: got %0d expected 11", bus.rej_cnt); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int valids;
    bus.start = 1'b1; bus.limit = 16'd3; rnd = $urandom;
    tick();
    n_total++; if (bus.busy !== 1'b1) $display("FAIL ign_busy: got %0b expected 1", bus.busy); else n_pass++;
    bus.limit = 16'hFFFF; rnd = $urandom;
    tick();
    rnd = 32'h0003 | ($urandom << 16);
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL ign_reject: got %0b expected 0", bus.out_valid); else n_pass++;
    rnd = 32'h0001 | ($urandom << 16);
    tick();
    rej_model++;
    n_total++; if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd1}) $display("FAIL ign_result: got %0b/%0h expected 1/1", bus.out_valid, bus.out_data); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      rnd = $urandom;
      tick();
      n_total++; if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd1}) $display("FAIL ign_hold: got %0b/%0h expected 1/1", bus.out_valid, bus.out_data); else n_pass++;
    end
    bus.out_ready = 1'b1;
    tick();
    n_total++; if ({bus.out_valid, bus.busy} !== 2'b00) $display("FAIL ign_exit: got %0b expected 00", {bus.out_valid, bus.busy}); else n_pass++;
    bus.start = 1'b0;
    valids = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.out_valid || bus.busy) valids++;
    end
    bus.out_ready = 1'b0;
    n_total++; if (valids !== 0) $display("FAIL ign_extra: got %0d busy/valid cycles expected 0", valids); else n_pass++;
    n_total++; if (int'(bus.rej_cnt) !== rej_model) $display("FAIL ign_rej: got %0d expected %0d", bus.rej_cnt, rej_model); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    logic [15:0] gd, ed; logic gf, ef, ge, ee; int gl, el;
    bus.start = 1'b1; bus.limit = 16'd5; rnd = $urandom;
    tick();
    bus.start = 1'b0;
    tick();
    rnd = 32'h0000FFFF;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    rej_model = 0;
    n_total++; if ({bus.busy, bus.out_valid} !== 2'b00) $display("FAIL mid_rst_flags: got %0b expected 00", {bus.busy, bus.out_valid}); else n_pass++;
    n_total++; if (bus.rej_cnt !== 16'd0) $display("FAIL mid_rst_rej: got %0d expected 0", bus.rej_cnt); else n_pass++;
    #2 rst = 1'b1;
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_idle: got %0b expected 0", bus.busy); else n_pass++;
    drive_req(16'd1, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
    n_total++; if ({gl, gd} !== {32'd2, 16'd0}) $display("FAIL mid_rst_req: got lat %0d data %0h expected 2/0", gl, gd); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] gd, ed, lim; logic gf, ef, ge, ee; int gl, el;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) lim = 16'($urandom_range(0, 20));
      else lim = 16'($urandom);
      drive_req(lim, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
      n_total++;
      if ({gl, gd, gf, ge} !== {el, ed, ef, ee})
        $display("FAIL rand_req lim %0h: got lat %0d data %0h fb %0b err %0b expected %0d/%0h/%0b/%0b", lim, gl, gd, gf, ge, el, ed, ef, ee);
      else n_pass++;
      n_total++; if (int'(bus.rej_cnt) !== rej_model) $display("FAIL rand_rej: got %0d expected %0d", bus.rej_cnt, rej_model); else n_pass++;
    end
  endtask

  task automatic test_statistics();
    logic [15:0] gd, ed; logic gf, ef, ge, ee; int gl, el;
    int hist[10];
    foreach (hist[i]) hist[i] = 0;
    use_xs = 1'b1;
    xs_x = 32'd123456789; xs_y = 32'd362436069; xs_z = 32'd521288629; xs_w = 32'd88675123;
    for (int i = 0; i < 10000; i++) begin
      drive_req(16'd10, 1'b1, gd, gf, ge, gl, ed, ef, ee, el);
      n_total++; if (gd >= 16'd10) $display("FAIL stat_range: got %0d expected below 10", gd); else n_pass++;
      n_total++; if ({gl, gd, gf} !== {el, ed, ef}) $display("FAIL stat_model: got %0d/%0d/%0b expected %0d/%0d/%0b", gl, gd, gf, el, ed, ef); else n_pass++;
      if (gd < 16'd10) hist[gd]++;
    end
    use_xs = 1'b0;
    for (int v = 0; v < 10; v++) begin
      n_total++; if (hist[v] < 900 || hist[v] > 1100) $display("FAIL stat_hist %0d: got %0d expected 900..1100", v, hist[v]); else n_pass++;
    end
    n_total++; if (int'(bus.rej_cnt) !== rej_model) $display("FAIL stat_rej: got %0d expected %0d", bus.rej_cnt, rej_model); else n_pass++;
  endtask

  task automatic test_saturation();
    int waited, exp_rej;
    rnd_sat = 32'h0000FFFF;
    for (int r = 1; r <= 258; r++) begin
      sat_if.start = 1'b1; sat_if.limit = 16'd5;
      tick();
      sat_if.start = 1'b0;
      waited = 0;
      while (!sat_if.out_valid && waited < 300) begin
        tick();
        waited++;
      end
      if (waited >= 300) begin
        n_total++;
        $display("FAIL sat_timeout: got no out_valid after %0d cycles expected one", waited);
      end
      exp_rej = (r * 255 > 65535) ? 65535 : r * 255;
      if (r == 1 || r == 256 || r == 257 || r == 258) begin
        n_total++; if (int'(sat_if.rej_cnt) !== exp_rej) $display("FAIL sat_rej r%0d: got %0d expected %0d", r, sat_if.rej_cnt, exp_rej); else n_pass++;
      end
      if (r == 1) begin
        n_total++; if ({sat_if.out_fallback, sat_if.out_data} !== {1'b1, 16'd2}) $display("FAIL sat_fb: got %0b/%0h expected 1/2", sat_if.out_fallback, sat_if.out_data); else n_pass++;
      end
      sat_if.out_ready = 1'b1;
      tick();
      sat_if.out_ready = 1'b0;
    end
  endtask

  initial begin
    n_total = 0; n_pass = 0; rej_model = 0; use_xs = 1'b0;
    xs_x = 32'd0; xs_y = 32'd0; xs_z = 32'd0; xs_w = 32'd0;
    rst = 1'b0; rnd = 32'h0; rnd_sat = 32'h0;
    bus.start = 1'b0; bus.limit = 16'h0; bus.out_ready = 1'b0;
    sat_if.start = 1'b0; sat_if.limit = 16'h0; sat_if.out_ready = 1'b0;
    #12;
    test_reset();
    #2 rst = 1'b1;
    tick();
    test_rejection();
    test_fallback();
    test_edge_limits();
    test_ignore_start();
    test_reset_mid_draw();
    test_random();
    fork
      test_statistics();
      test_saturation();
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rand_range.md
Name: rand_range

Overview:
- Consumer stage placed directly downstream of the 32-bit xorshift generator.
- Reduces the free-running random word to an unbiased integer in [0, limit) using masked rejection sampling.
- Bounded retry count with a deterministic fallback; valid/ready output handshake.
- Used by game/demo logic needing dice, positions or indices.

Parameters:
W, 16, output/limit width; candidate taken from rnd[W-1:0]
MAX_TRY, 8, max draws per request before fallback (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  request pulse; sampled only in IDLE
limit  input  W  exclusive upper bound; latched when start accepted
rnd  input  32  generator output; new value every clk
busy  output  1  high in any state other than IDLE
out_valid  output  1  result available; held until accepted
out_ready  input  1  consumer accepts result when out_valid & out_ready at a clk edge
out_data  output  W  result, stable while out_valid
out_fallback  output  1  result produced by fallback path, valid with out_valid
out_err  output  1  request had limit==0, valid with out_valid
rej_cnt  output  16  saturating count of rejected candidates since reset

Behaviour:
- Reset (rst=0, async): state=IDLE. busy, out_valid, out_fallback and out_err = 0. out_data=0, rej_cnt=0, internal lim/mask/try = 0. Takes effect immediately, also mid-request; the pending request is discarded.
- States:
  - IDLE: busy=0. Edge with start=1: lim<=limit, try<=0, go SETUP. If start=0, stay.
  - SETUP (1 cycle):
    - lim==0: out_data<=0, out_err<=1, out_fallback<=0, out_valid<=1, go DONE.
    - Else mask <= smallest (2^k - 1) >= lim-1 (OR-smear of lim-1; lim=1 -> mask=0), go DRAW.
  - DRAW: each edge computes c = rnd[W-1:0] & mask.
    - c < lim: out_data<=c, out_fallback<=0, out_err<=0, out_valid<=1, go DONE.
    - Else rej_cnt++ (saturating at 0xFFFF) and try++.
    - If that rejection is the MAX_TRY-th: out_data<=c-lim (always < lim because mask < 2*lim), out_fallback<=1, out_valid<=1, go DONE.
    - Otherwise stay in DRAW.
  - DONE: outputs held stable. Edge with out_ready=1: out_valid<=0, go IDLE. out_fallback/out_err/out_data keep their last values.
- Latency: start accepted at edge E0, mask at E1, first candidate sampled at E2. Best case out_valid rises after E2; worst case after E(1+MAX_TRY).
- One rnd sample per cycle, never reused. rnd[31:W] unused.
- start is ignored in SETUP, DRAW and DONE, including the cycle where DONE is exited. A new request needs start=1 while in IDLE, so the minimum request period is 4 cycles.
- limit changes after acceptance have no effect.
- out_ready while out_valid=0 has no effect.
- Arithmetic: unsigned W-bit compare and subtract. limit = 2^W-1 gives mask = 2^W-1.

Test Plan:
- Reset mid-DRAW: drive rst=0 asynchronously between edges -> busy, out_valid and rej_cnt read 0 immediately. After release, the FSM is in IDLE and a new start is accepted.
- Rejection path: limit=6, start at E0, rnd[15:0] = 0x0007 at E2, 0x0006 at E3, 0x0003 at E4 -> mask=7, out_valid rises after E4, out_data=3, out_fallback=0, rej_cnt=2. out_valid holds 3 cycles with out_ready=0, then drops one edge after out_ready=1.
- Fallback: MAX_TRY=8, limit=5 (mask=7), rnd[15:0]=0x0007 for 8 draws -> out_data=2, out_fallback=1, out_valid after E9, rej_cnt=8.
- Edge limits: limit=1 with random rnd -> out_data=0 after E2, no rejection. limit=0 -> out_err=1, out_data=0, out_valid after E1. limit=0xFFFF, rnd=0x1234FFFF then 0x0000ABCD -> one reject, out_data=0xABCD.
- Handshake/ignore: pulse start during DRAW and DONE, and while limit changes -> no extra result. Only one out_valid per accepted request; the latched limit is used.
- Saturation/statistics: 10,000 requests with limit=10 from a reference xorshift (seed 123456789/362436069/521288629/88675123) -> every out_data < 10, each value 0..9 within ±10% of 1000. rej_cnt matches the bench model and stops at 0xFFFF when forced over.
